image_stream_tx: RTL
====================

# image_stream_tx

Frame source for the image pipeline. It reads a stored BMP-ordered frame from a pixel-pair memory and streams it top row first, two pixels per clock, on the HSYNC/DATA_*0/DATA_*1 interface. The frame-writer and processing stages consume this same interface. It sits at the head of the pipeline. It generates the VSYNC start-of-frame interval, per-line HSYNC windows and horizontal blanking, and signals frame completion.

## Interface
Parameters:
- WIDTH, 768, pixels per row; must be even.
- HEIGHT, 512, rows per frame.
- HBLANK, 160, idle cycles between consecutive line read windows; must be ≥ 1.
- VSYNC_CYCLES, 100, cycles VSYNC is held high before the first line.
- ADDR_W, 18, memory word-address width; must be ≥ clog2(WIDTH*HEIGHT/2).

Ports:
- HCLK  in  1  clock; all logic on the rising edge.
- HRESET  in  1  reset, asynchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  pixel-pair word address.
- mem_rdata  in  48  word returned exactly 1 cycle after mem_rd_en.
  - Byte lanes: [7:0] B0, [15:8] G0, [23:16] R0, [31:24] B1, [39:32] G1, [47:40] R1.
- VSYNC  out  1  start-of-frame interval.
- HSYNC  out  1  pixel pair valid on DATA_*.
- DATA_R0, DATA_G0, DATA_B0  out  8 each  left (even-column) pixel.
- DATA_R1, DATA_G1, DATA_B1  out  8 each  right (odd-column) pixel.
- ctrl_done  out  1  one-cycle end-of-frame pulse.

## Operation
FSM states and transitions:
- IDLE: waits for start. When start=1, go to VSYNC.
- VSYNC: VSYNC=1 for exactly VSYNC_CYCLES cycles, then go to LINE with row=0, col=0.
- LINE: mem_rd_en=1 for WIDTH/2 cycles, col 0..WIDTH/2-1.
  - mem_addr = (HEIGHT-1-row)*(WIDTH/2) + col. The memory holds the frame bottom-up; the output is top-down.
  - At the last col: if row==HEIGHT-1, go to DONE; otherwise go to BLANK.
- BLANK: no reads for HBLANK cycles. Then row increments, col=0, go to LINE.
- DONE: waits one cycle for the last data beat, asserts ctrl_done for one cycle, then returns to IDLE.

Output and control rules:
- The output stage registers mem_rd_en and mem_rdata.
  - HSYNC = mem_rd_en delayed by 1 cycle.
  - DATA_* are loaded from the byte lanes when the delayed strobe is 1, and forced to 0 otherwise.
- start is ignored outside IDLE; a frame in progress is never restarted.
- A start that is held high continuously produces back-to-back frames. The next frame begins with the first IDLE cycle after ctrl_done.
- Counters are sized from the parameters; the address arithmetic must not truncate below ADDR_W.

## Timing
- Reset values: all outputs 0, FSM IDLE, row=col=0.
- Reset asserted mid-frame takes effect immediately (asynchronous). Any pending read is discarded, and no HSYNC or ctrl_done follows.
- Frame timeline (start sampled at cycle 0):
  - VSYNC high for cycles 1..VSYNC_CYCLES.
  - First read at cycle VSYNC_CYCLES+1, first HSYNC one cycle later.
  - Line period is WIDTH/2 + HBLANK cycles.
  - HSYNC is low for exactly HBLANK cycles between lines.
- ctrl_done goes high 2 cycles after the last read, i.e. the cycle after the final HSYNC beat.
- Read-to-data latency is fixed at 1. mem_rdata is don't-care when not requested.

## Structure
- Shared package image_pkg holds:
  - default WIDTH/HEIGHT;
  - byte-lane offset localparams for the 48-bit pixel-pair word;
  - the FSM state enum (IDLE, VSYNC, LINE, BLANK, DONE).
- One sub-module, image_scan_counter: the row/col counter with terminal-count flags (last_col, last_row) and a clear input.
- The FSM, address computation and output register stage stay in the top.

## Test plan
All scenarios use WIDTH=8, HEIGHT=4, HBLANK=2, VSYNC_CYCLES=3, and a behavioural 1-cycle memory whose word n holds n in every byte lane.
- Reset, then start pulse at cycle 0 → VSYNC=1 at cycles 1–3 only. Reads at cycles 4–7 with addresses 12,13,14,15. HSYNC at 5–8 with DATA_R0=12..15.
- Full frame → row address bases in output order are 12, 8, 4, 0. Read windows start at cycles 4, 10, 16, 22. Last HSYNC at cycle 26, ctrl_done only at cycle 27, IDLE at cycle 28.
- Lane mapping with word 0x0605_0403_0201 at address 12 → first beat shows B0=01, G0=02, R0=03, B1=04, G1=05, R1=06.
- start pulsed again at cycles 6 and 15 mid-frame → ignored: identical timeline and exactly one ctrl_done.
- HRESET asserted at cycle 12 for one cycle → all outputs 0 at once and no ctrl_done. A new start at cycle 20 reproduces the first-scenario timeline offset by 20.
- start held high → a second VSYNC window begins at cycle 29, and no HSYNC occurs during any VSYNC cycle.

Source files
------------

// File: rtl/image_pkg.sv
// Shared types and constants for the image streaming pipeline.
// Holds frame defaults, pixel-pair byte lanes and the source FSM states.
package image_pkg;

  localparam int WIDTH_DEF  = 768;
  localparam int HEIGHT_DEF = 512;

  localparam int B0_LSB = 0;
  localparam int G0_LSB = 8;
  localparam int R0_LSB = 16;
  localparam int B1_LSB = 24;
  localparam int G1_LSB = 32;
  localparam int R1_LSB = 40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_LINE,
    ST_BLANK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/image_scan_counter.sv
// Row/column scan position with terminal-count flags.
// The column wraps to zero on its own after the last pixel pair.
module image_scan_counter #(
  parameter int COLS = 384,
  parameter int ROWS = 512,
  localparam int CW = $clog2(COLS > 1 ? COLS : 2),
  localparam int RW = $clog2(ROWS > 1 ? ROWS : 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          col_inc_i,
  input  logic          row_inc_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_col_o,
  output logic          last_row_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign last_col_o = (col_q == CW'(COLS - 1));
  assign last_row_o = (row_q == RW'(ROWS - 1));
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else begin
      if (col_inc_i)
        col_d = last_col_o ? '0 : col_q + 1'b1;
      if (row_inc_i)
        row_d = last_row_o ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/image_stream_tx.sv
// Frame source: scans a bottom-up pixel-pair memory and streams it
// top row first with VSYNC, HSYNC windows, blanking and a done pulse.
module image_stream_tx
  import image_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int HEIGHT       = HEIGHT_DEF,
  parameter int HBLANK       = 160,
  parameter int VSYNC_CYCLES = 100,
  parameter int ADDR_W       = 18
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [47:0]       mem_rdata,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic [7:0]        DATA_R0,
  output logic [7:0]        DATA_G0,
  output logic [7:0]        DATA_B0,
  output logic [7:0]        DATA_R1,
  output logic [7:0]        DATA_G1,
  output logic [7:0]        DATA_B1,
  output logic              ctrl_done
);

  localparam int COLS = WIDTH / 2;
  localparam int CW   = $clog2(COLS > 1 ? COLS : 2);
  localparam int RW   = $clog2(HEIGHT > 1 ? HEIGHT : 2);
  localparam int TMAX = VSYNC_CYCLES > HBLANK ? VSYNC_CYCLES : HBLANK;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          dwait_q, dwait_d;
  logic          rd_q;

  logic          clr, col_inc, row_inc;
  logic          last_col, last_row;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [RW-1:0] row_rev;
  logic [ADDR_W-1:0] addr;

  image_scan_counter #(
    .COLS(COLS),
    .ROWS(HEIGHT)
  ) u_scan (
    .clk       (HCLK),
    .rst       (HRESET),
    .clr_i     (clr),
    .col_inc_i (col_inc),
    .row_inc_i (row_inc),
    .col_o     (col),
    .row_o     (row),
    .last_col_o(last_col),
    .last_row_o(last_row)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    dwait_d   = 1'b0;
    clr       = 1'b0;
    col_inc   = 1'b0;
    row_inc   = 1'b0;
    mem_rd_en = 1'b0;
    VSYNC     = 1'b0;
    ctrl_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clr   = 1'b1;
        tmr_d = '0;
        if (start)
          state_d = ST_VSYNC;
      end
      ST_VSYNC: begin
        VSYNC = 1'b1;
        if (tmr_q == TW'(VSYNC_CYCLES - 1)) begin
          tmr_d   = '0;
          clr     = 1'b1;
          state_d = ST_LINE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_LINE: begin
        mem_rd_en = 1'b1;
        col_inc   = 1'b1;
        if (last_col)
          state_d = last_row ? ST_DONE : ST_BLANK;
      end
      ST_BLANK: begin
        if (tmr_q == TW'(HBLANK - 1)) begin
          tmr_d   = '0;
          row_inc = 1'b1;
          state_d = ST_LINE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_DONE: begin
        // first cycle lets the final beat drain, second one reports
        dwait_d = 1'b1;
        if (dwait_q) begin
          dwait_d   = 1'b0;
          ctrl_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      dwait_q <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dwait_q <= dwait_d;
      rd_q    <= mem_rd_en;
    end
  end

  // memory stores rows bottom-up, so flip the row index
  assign row_rev  = RW'(HEIGHT - 1) - row;
  assign addr     = ADDR_W'(row_rev) * ADDR_W'(COLS) + ADDR_W'(col);
  assign mem_addr = mem_rd_en ? addr : '0;

  assign HSYNC   = rd_q;
  assign DATA_B0 = rd_q ? mem_rdata[B0_LSB +: 8] : '0;
  assign DATA_G0 = rd_q ? mem_rdata[G0_LSB +: 8] : '0;
  assign DATA_R0 = rd_q ? mem_rdata[R0_LSB +: 8] : '0;
  assign DATA_B1 = rd_q ? mem_rdata[B1_LSB +: 8] : '0;
  assign DATA_G1 = rd_q ? mem_rdata[G1_LSB +: 8] : '0;
  assign DATA_R1 = rd_q ? mem_rdata[R1_LSB +: 8] : '0;

endmodule
